mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Pipeline MEM stage. Consumes the ex_mem_t bundle from ex_stage and drives the data-memory req/gnt/rvalid bus.
//  Generates byte enables and extends load data. Stalls the pipeline until the access completes.
//  Owns the MEM/WB register (mem_wb_t). Exports aluresult_m to the forwarding path and stall_m to the hazard unit.
// PARAMETERS
//  TIMEOUT  256  cycles a bus access may wait in REQ/RSP before forced completion with bus_err (>=2)
// PORTS
//  clk           in   1        core clock; all state on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  in            in   ex_mem_t from EX/MEM reg; uses aluresult, writedata, funct3, rd, regwrite, resultsrc, memwrite, pcplus4
//  aluresult_m   out  32       = in.aluresult (combinational), forwarding source into ex_stage
//  stall_m       out  1        high while the current MEM op is incomplete; freezes F/D/E/M regs
//  dmem_req      out  1        bus request
//  dmem_we       out  1        1 = store
//  dmem_addr     out  32       {in.aluresult[31:2],2'b00}
//  dmem_be       out  4        byte enables
//  dmem_wdata    out  32       store data lane-replicated
//  dmem_gnt      in   1        request accepted this cycle
//  dmem_rvalid   in   1        load data valid
//  dmem_rdata    in   32       load data word
//  misaligned    out  1        1-cycle pulse: misaligned access squashed
//  bus_err       out  1        1-cycle pulse: access timed out
//  out           out  mem_wb_t registered: aluresult, readdata, pcplus4, rd, regwrite, resultsrc
// BEHAVIOUR
//  mem op: load = (in.resultsrc==2'b01); store = in.memwrite. Other ops pass straight to out with 1-cycle latency.
//  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
//  BE: B = 1<<a[1:0]; H = 4'b0011<<a[1:0]; W = 4'b1111.
//  wdata: B = {4{wd[7:0]}}; H = {2{wd[15:0]}}; W = wd.
//  Load extend: select byte/half at a[1:0]; sign-extend for B/H, zero-extend for BU/HU.
//  Misaligned: H with a[0]!=0, or W with a[1:0]!=0.
//    No request is issued. The op completes immediately with regwrite forced 0 and misaligned pulses.
//  FSM states IDLE, REQ, RSP. Reset -> IDLE.
//   IDLE: aligned mem op -> dmem_req=1 combinationally.
//         gnt & store -> done this cycle, stay IDLE.
//         gnt & load -> RSP. !gnt -> REQ.
//   REQ:  hold req/we/addr/be/wdata stable until gnt.
//         gnt & store -> IDLE (done). gnt & load -> RSP.
//   RSP:  dmem_req=0. rvalid -> IDLE (done); rdata extended and captured.
//  rvalid is sampled only in RSP, and never in the same cycle as its gnt. rvalid in IDLE/REQ is ignored.
//  stall_m = mem op & !done.
//  Minimum latency, zero-wait bus: store 0 stall cycles; load 1 stall cycle.
//  Timeout counter (clog2(TIMEOUT) bits):
//    Cleared on entry to REQ/RSP, increments each cycle in REQ/RSP.
//    At TIMEOUT-1 the op is forced done: readdata=0, regwrite=0, bus_err pulses, FSM -> IDLE.
//  MEM/WB register:
//    Done or non-mem op -> capture fields (readdata=0 for non-loads).
//    stall_m=1 -> load a bubble (regwrite=0, rd=0), so WB never repeats a write.
//  Reset (async, any state):
//    FSM=IDLE, counter=0, out='0, misaligned=0, bus_err=0.
//    dmem_req drops immediately. Any response in flight is dropped.
//  Simultaneous timeout and gnt/rvalid in the same cycle: the bus event wins and the op completes normally.
// STRUCTURE
//  core_pkg (shared):
//    ex_mem_t gains funct3[2:0]; new mem_wb_t.
//    localparams RESSRC_MEM=2'b01 and F3_B/H/W/BU/HU.
//    mem_state_t enum.
//  Sub-module: lsu_align (combinational). BE/wdata generation, load extension and misalignment detect.
//  FSM, counter and MEM/WB register are in mem_stage.
// TESTING
//  1 SW addr 0x104, wd 0xDEADBEEF, gnt same cycle:
//    req/we=1, be=1111, stall_m=0; out.regwrite=0 next cycle.
//  2 SB addr 0x103, wd 0x000000A5:
//    be=1000, wdata=0xA5A5A5A5, addr=0x100.
//  3 LB addr 0x102, gnt cycle 0, rvalid cycle 2, rdata 0x12F45678:
//    stall_m high cycles 0-1; out.readdata=0xFFFFFFF4.
//    LBU same stimulus -> 0x000000F4.
//  4 LH addr 0x101:
//    no req, misaligned pulse, stall_m=0, out.regwrite=0.
//  5 LW, gnt withheld, TIMEOUT=8:
//    req held with stable addr for 8 cycles, bus_err pulse, readdata=0, FSM IDLE.
//  6 rst_n low while in RSP:
//    req=0, out='0 asynchronously. A later stray rvalid is ignored and the next ADD passes with 1-cycle latency.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline types for the core.
//   ex_mem_t    : EX/MEM register contents consumed by the MEM stage
//   mem_wb_t    : MEM/WB register contents produced by the MEM stage
//   mem_state_t : MEM-stage bus FSM states (exported for debug)
//   RESSRC_MEM  : resultsrc encoding that marks a load
//   F3_*        : funct3 access-size codes
package core_pkg;

  localparam logic [1:0] RESSRC_MEM = 2'b01;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite;
    logic [31:0] pcplus4;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
  } mem_wb_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane alignment.
//   addr_lo_i    : byte offset of the access within the word
//   funct3_i     : access size / signedness (unknown codes behave as W)
//   wdata_i      : store data from the register file
//   rdata_i      : raw load word from the bus
//   be_o         : byte enables for the bus
//   wdata_o      : store data replicated across all lanes
//   rdata_o      : load data, selected and sign/zero extended
//   misaligned_o : access crosses its natural alignment
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                          : {16'b0, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data-memory bus, stalls until the access
// completes, and owns the MEM/WB register.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in                 : EX/MEM bundle (held stable by the pipeline while stall_m)
//   aluresult_m        : forwarding source, straight from in.aluresult
//   stall_m            : current mem op not yet complete
//   dmem_*             : data-memory bus (req/gnt address phase, rvalid data phase)
//   misaligned, bus_err: one-cycle pulses, aligned with the squashed MEM/WB entry
//   out                : MEM/WB register
//   dbg_state_o        : current bus FSM state
//
// Bus handshake: dmem_req is the valid, dmem_gnt the ready. Once req is
// raised, req/we/addr/be/wdata stay stable until the cycle gnt is seen high;
// that cycle is the transfer. Load data arrives later on rvalid, which is
// only looked at in RSP (so never in the same cycle as its own gnt).
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT = 256
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     in,
  output logic [31:0] aluresult_m,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misaligned,
  output logic        bus_err,
  output mem_wb_t     out,
  output mem_state_t  dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_wb_t          out_q, out_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_err_q, bus_err_d;

  logic        is_load, is_store, mem_op;
  logic        mis_c;
  logic [31:0] rdata_ext;
  logic        req_c, done_c, load_ok_c, timeout_c, squash_mis_c, tmo_hit;

  assign is_load  = (in.resultsrc == RESSRC_MEM);
  assign is_store = in.memwrite;
  assign mem_op   = is_load | is_store;

  lsu_align u_align (
    .addr_lo_i    (in.aluresult[1:0]),
    .funct3_i     (in.funct3),
    .wdata_i      (in.writedata),
    .rdata_i      (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .rdata_o      (rdata_ext),
    .misaligned_o (mis_c)
  );

  assign tmo_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_c        = 1'b0;
    done_c       = 1'b0;
    load_ok_c    = 1'b0;
    timeout_c    = 1'b0;
    squash_mis_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          if (mis_c) begin
            done_c       = 1'b1;
            squash_mis_c = 1'b1;
          end else begin
            req_c = 1'b1;
            cnt_d = '0;
            if (dmem_gnt) begin
              if (is_store) done_c  = 1'b1;
              else          state_d = ST_RSP;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        // A grant in the timeout cycle still counts: the bus event wins.
        if (dmem_gnt) begin
          if (is_store) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RSP;
            cnt_d   = '0;
          end
        end else if (tmo_hit) begin
          done_c    = 1'b1;
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (dmem_rvalid) begin
          done_c    = 1'b1;
          load_ok_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmo_hit) begin
          done_c    = 1'b1;
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM/WB: capture on completion (or non-mem op); insert a bubble while
  // stalled so WB never sees the same write twice.
  always_comb begin
    out_d        = '0;
    misaligned_d = squash_mis_c;
    bus_err_d    = timeout_c;
    if (!mem_op || done_c) begin
      out_d.aluresult = in.aluresult;
      out_d.readdata  = load_ok_c ? rdata_ext : 32'b0;
      out_d.pcplus4   = in.pcplus4;
      out_d.rd        = in.rd;
      out_d.regwrite  = in.regwrite & ~squash_mis_c & ~timeout_c;
      out_d.resultsrc = in.resultsrc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_q        <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign aluresult_m = in.aluresult;
  assign stall_m     = mem_op & ~done_c;
  // IDLE issues the request combinationally; gating with rst_n makes it
  // drop the moment reset asserts rather than at the next edge.
  assign dmem_req    = req_c & rst_n;
  assign dmem_we     = is_store;
  assign dmem_addr   = {in.aluresult[31:2], 2'b00};
  assign misaligned  = misaligned_q;
  assign bus_err     = bus_err_q;
  assign out         = out_q;
  assign dbg_state_o = state_q;

endmodule
